wb_arbiter: RTL

Write-back arbiter that owns the register file's single write port (`wr_addr0`/`wr_din0`/`we0`) in the RISC-V core. It merges single-cycle ALU results with variable-latency load results. Loads are buffered in a small in-order queue. Younger ALU writes kill older queued loads to the same register, which prevents WAW corruption. Writes to x0 are never issued.

---
 rtl/wb_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter
//
// Owns the register file's single write port. It merges single-cycle ALU
// results with variable-latency load results. Loads wait in an in-order queue.
// An ALU write that is accepted kills every queued load with the same rd.
// This stops an older load from overwriting a younger ALU result (WAW).
// Writes to x0 are never issued.
//
// Optional feature: define WB_BYPASS_EN to add the combinational forwarding
// ports rd_addr0/1, fwd_hit0/1 and fwd_data0/1.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data  ALU result (no backpressure, highest priority)
//   ld_valid/ld_ready/ld_rd/ld_data  load result handshake into the queue
//   wr_addr0/wr_din0/we0     registered register-file write port
//   lq_count                 occupied queue entries (killed entries included)
//   busy                     queue non-empty or a write is in flight
//   rd_addr0/1, fwd_hit0/1, fwd_data0/1  bypass (WB_BYPASS_EN only)

module wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LQ_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    input  logic [ADDR_W-1:0]            alu_rd,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [ADDR_W-1:0]            ld_rd,
    input  logic [DATA_W-1:0]            ld_data,
    output logic [ADDR_W-1:0]            wr_addr0,
    output logic [DATA_W-1:0]            wr_din0,
    output logic                         we0,
    output logic [$clog2(LQ_DEPTH):0]    lq_count,
    output logic                         busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]            rd_addr0,
    input  logic [ADDR_W-1:0]            rd_addr1,
    output logic                         fwd_hit0,
    output logic                         fwd_hit1,
    output logic [DATA_W-1:0]            fwd_data0,
    output logic [DATA_W-1:0]            fwd_data1
`endif
);

    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);

    logic [DATA_W-1:0]   lq_data [LQ_DEPTH];
    logic [ADDR_W-1:0]   lq_rd   [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] lq_valid;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;

    logic alu_win;
    logic push;
    logic pop;
    logic push_live;

    // ld_ready looks only at the registered count. A pop in the same cycle
    // does not raise it, which keeps the handshake free of combinational paths.
    assign ld_ready = !rst && (lq_count < DEPTH_C);
    assign busy     = (lq_count != '0) || we0;

    always_comb begin
        alu_win   = alu_valid && (alu_rd != '0);
        // A load to x0 completes the handshake but never occupies an entry.
        push      = ld_valid && ld_ready && (ld_rd != '0);
        pop       = !alu_win && (lq_count != '0);
        // A load arriving together with an ALU write to the same rd is older
        // than that write, so it is stored already dead.
        push_live = !(alu_win && (ld_rd == alu_rd));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lq_valid <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lq_count <= '0;
        end else begin
            // Unoccupied slots may be cleared too. Occupancy is tracked by
            // lq_count, so clearing them has no effect.
            for (int i = 0; i < LQ_DEPTH; i++) begin
                if (alu_win && (lq_rd[i] == alu_rd)) begin
                    lq_valid[i] <= 1'b0;
                end
            end
            if (push) begin
                lq_valid[wr_ptr] <= push_live;
                lq_rd[wr_ptr]    <= ld_rd;
                lq_data[wr_ptr]  <= ld_data;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   lq_count <= lq_count + CW'(1);
                2'b01:   lq_count <= lq_count - CW'(1);
                default: lq_count <= lq_count;
            endcase
        end
    end

    // A popped head is never killed in its own pop cycle, because a pop only
    // happens when no ALU write is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            we0      <= 1'b0;
            wr_addr0 <= '0;
            wr_din0  <= '0;
        end else if (alu_win) begin
            we0      <= 1'b1;
            wr_addr0 <= alu_rd;
            wr_din0  <= alu_data;
        end else if (pop) begin
            we0      <= lq_valid[rd_ptr];
            wr_addr0 <= lq_rd[rd_ptr];
            wr_din0  <= lq_data[rd_ptr];
        end else begin
            we0      <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    // This covers a register file that does not write through in the same
    // cycle: a read of the register being written sees the new value.
    assign fwd_hit0  = we0 && (wr_addr0 == rd_addr0) && (rd_addr0 != '0);
    assign fwd_hit1  = we0 && (wr_addr0 == rd_addr1) && (rd_addr1 != '0);
    assign fwd_data0 = wr_din0;
    assign fwd_data1 = wr_din0;
`endif

endmodule
